// File: rtl/rom_port_arbiter_pkg.sv
// Shared types for the instruction-ROM port arbiter.
// Owner encoding, default ROM base and the pending-response record.
package rom_port_arbiter_pkg;

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [31:0] ROM_BASE_DEFAULT = 32'h0040_0000;

    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
    } pend_t;

endpackage

// File: rtl/rom_arb_grant.sv
// Fetch-priority grant with a starvation guard for the data port.
// Holds the burst counter of consecutive F grants made while D waits.
module rom_arb_grant #(
    parameter int MAX_F_BURST = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_f_valid,
    input  logic i_d_valid,
    output logic o_grant_f,
    output logic o_grant_d
);

    localparam logic [3:0] MAX_C = 4'(MAX_F_BURST);

    logic [3:0] r_burst_cnt;
    logic       w_limit;
    logic       w_grant_f;
    logic       w_grant_d;

    assign w_limit   = (r_burst_cnt == MAX_C);
    assign w_grant_d = !reset && i_d_valid && (!i_f_valid || w_limit);
    assign w_grant_f = !reset && i_f_valid && !w_grant_d;

    assign o_grant_f = w_grant_f;
    assign o_grant_d = w_grant_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_burst_cnt <= '0;
        end else if (!i_d_valid || w_grant_d) begin
            r_burst_cnt <= '0;
        end else if (w_grant_f && !w_limit) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the registered-read instruction ROM between fetch (F) and data (D).
// Optional grant/stall statistics are enabled by defining ROM_ARB_STATS_EN.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter logic [31:0] ROM_BASE_PC = ROM_BASE_DEFAULT,
    parameter int          ADDR_WIDTH  = 8,
    parameter int          MAX_F_BURST = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req_valid,
    input  logic [31:0] f_req_addr,
    output logic        f_req_ready,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_data,
    output logic        f_rsp_err,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
`ifdef ROM_ARB_STATS_EN
    output logic [15:0] f_grant_cnt,
    output logic [15:0] d_grant_cnt,
    output logic [15:0] stall_cnt,
`endif
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data
);

    logic        w_grant_f;
    logic        w_grant_d;
    logic        w_accept;
    logic [31:0] w_addr;
    logic [31:0] w_off;
    logic        w_in_range;
    logic        w_err;
    logic        w_f_rsp;
    logic        w_d_rsp;
    pend_t       r_pend;
    logic [31:0] r_f_data;
    logic [31:0] r_d_data;

    rom_arb_grant #(
        .MAX_F_BURST (MAX_F_BURST)
    ) u_grant (
        .clock     (clock),
        .reset     (reset),
        .i_f_valid (f_req_valid),
        .i_d_valid (d_req_valid),
        .o_grant_f (w_grant_f),
        .o_grant_d (w_grant_d)
    );

    assign w_accept = w_grant_f || w_grant_d;
    assign w_addr   = w_grant_d ? d_req_addr : f_req_addr;
    assign w_off    = w_addr - ROM_BASE_PC;

    // Offset shifted past the window size must be zero to stay in range.
    assign w_in_range = (w_addr >= ROM_BASE_PC) &&
                        ((w_off >> (ADDR_WIDTH + 2)) == 32'd0);
    assign w_err      = !w_in_range || (w_addr[1:0] != 2'b00);

    assign f_req_ready = w_grant_f;
    assign d_req_ready = w_grant_d;
    assign rom_en      = w_accept && !w_err;
    assign rom_addr    = rom_en ? w_addr : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend.valid <= w_accept;
            r_pend.owner <= w_grant_d ? OWN_D : OWN_F;
            r_pend.err   <= w_accept && w_err;
        end
    end

    assign w_f_rsp = !reset && r_pend.valid && (r_pend.owner == OWN_F);
    assign w_d_rsp = !reset && r_pend.valid && (r_pend.owner == OWN_D);

    assign f_rsp_valid = w_f_rsp;
    assign d_rsp_valid = w_d_rsp;
    assign f_rsp_err   = w_f_rsp && r_pend.err;
    assign d_rsp_err   = w_d_rsp && r_pend.err;

    // Non-owner data holds its last delivered word.
    assign f_rsp_data = w_f_rsp ? (r_pend.err ? 32'd0 : rom_data) : r_f_data;
    assign d_rsp_data = w_d_rsp ? (r_pend.err ? 32'd0 : rom_data) : r_d_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_f_data <= '0;
            r_d_data <= '0;
        end else begin
            r_f_data <= f_rsp_data;
            r_d_data <= d_rsp_data;
        end
    end

`ifdef ROM_ARB_STATS_EN
    logic [15:0] r_f_grant_cnt;
    logic [15:0] r_d_grant_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (f_req_valid && !w_grant_f) ||
                     (d_req_valid && !w_grant_d);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_f_grant_cnt <= '0;
            r_d_grant_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_grant_f && r_f_grant_cnt != 16'hFFFF)
                r_f_grant_cnt <= r_f_grant_cnt + 16'd1;
            if (w_grant_d && r_d_grant_cnt != 16'hFFFF)
                r_d_grant_cnt <= r_d_grant_cnt + 16'd1;
            if (w_stall && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign f_grant_cnt = r_f_grant_cnt;
    assign d_grant_cnt = r_d_grant_cnt;
    assign stall_cnt   = r_stall_cnt;
`endif

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-ported, registered-read instruction ROM between two requesters.
  - Port F: the instruction fetch stage.
  - Port D: the data-side load path or loader/debug reads of the text segment.
- Sits between the fetch/memory stages and the ROM.
- Arbitration: fetch-priority with a starvation guard.
- Responses return one cycle after acceptance, tagged back to the owning port; out-of-range addresses are flagged.

Parameters:
- ROM_BASE_PC, 32'h0040_0000, byte address of ROM word 0.
- ADDR_WIDTH, 8, ROM index width; window is 4*(1<<ADDR_WIDTH) bytes.
- MAX_F_BURST, 4, consecutive F grants allowed while D is waiting before D is forced (range 1..15).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- f_req_valid  in  1  fetch request.
- f_req_addr  in  32  fetch byte address.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_rsp_valid  out  1  fetch response valid.
- f_rsp_data  out  32  fetch instruction word.
- f_rsp_err  out  1  fetch address was out of range or unaligned.
- d_req_valid, d_req_addr, d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err: same as F, for port D.
- rom_en  out  1  ROM read enable.
- rom_addr  out  32  ROM byte address (the ROM subtracts the base itself).
- rom_data  in  32  ROM output, valid the cycle after rom_en.

Behaviour:
- Reset:
  - All ready/rsp_valid/err outputs are 0.
  - rsp_data is 0 and rom_en is 0.
  - Burst counter is 0 and the pending tag is cleared.
- Handshake:
  - A request is accepted when valid && ready.
  - The requester holds addr stable while valid && !ready.
  - Responses have no backpressure.
- Grant is combinational from valid bits and the burst counter; at most one ready per cycle.
  - Only F valid: grant F.
  - Only D valid: grant D.
  - Both valid: grant F unless burst_cnt == MAX_F_BURST, in which case grant D.
- Burst counter:
  - Increments on an F grant while d_req_valid is high; saturates at MAX_F_BURST.
  - Clears on a D grant, or when d_req_valid is low.
- Issue:
  - A granted in-range, word-aligned address drives rom_en=1 and rom_addr=addr in the same cycle.
  - Out-of-range means addr < ROM_BASE_PC or addr >= ROM_BASE_PC + 4*(1<<ADDR_WIDTH). Unaligned means addr[1:0] != 0.
  - Out-of-range or unaligned requests are still accepted, with rom_en=0.
- Pending register, loaded at acceptance: {valid, owner, err}.
- Response:
  - Exactly 1 cycle after acceptance, the owner's rsp_valid=1 for one cycle.
  - rsp_data = rom_data, or 0 if err; rsp_err = err.
  - The non-owner's rsp_valid stays 0; its data holds its previous value.
- Throughput: one acceptance per cycle; back-to-back responses are allowed, including alternating owners.
- Idle (no valid): rom_en=0, pending valid cleared.
- Reset while a read is pending: the response is dropped; rsp_valid is 0 in the cycle after reset.
- Simultaneous arrival with counter below limit: F wins; D waits with ready=0.

Optional Feature:
- Macro: ROM_ARB_STATS_EN.
- Defined:
  - Adds outputs f_grant_cnt[15:0], d_grant_cnt[15:0] and stall_cnt[15:0].
  - stall_cnt counts cycles with a valid request and ready low, per any port.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and their registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - Owner encoding (OWN_F=1'b0, OWN_D=1'b1).
  - Default ROM_BASE_PC.
  - The pending-record struct {valid, owner, err}.
- One natural sub-module: rom_arb_grant.
  - Combinational priority + starvation logic, plus the burst counter register.
  - Keeps the arbitration policy separately testable.
- Range check and response steering stay in the top.

Test Plan:
- F-only stream, addrs 0x0040_0000, 0x0040_0004, 0x0040_0008 on consecutive cycles -> three f_rsp_valid pulses one cycle later with ROM words 0,1,2; d_rsp_valid stays 0.
- F and D valid continuously, MAX_F_BURST=4 -> grant sequence F,F,F,F,D repeating; D accepted on cycle 5.
- D request at 0x003F_FFFC -> d_req_ready=1, rom_en=0; next cycle d_rsp_valid=1, d_rsp_err=1, d_rsp_data=0.
- F at 0x0040_0402 (out of window for ADDR_WIDTH=8) and unaligned 0x0040_0006 -> f_rsp_err=1 for both, data 0.
- Reset asserted the cycle after an F acceptance -> f_rsp_valid stays 0; all outputs and counters zero; normal operation resumes after deassertion.
- With ROM_ARB_STATS_EN, 10 F grants plus 3 D grants and 2 stall cycles -> f_grant_cnt=10, d_grant_cnt=3, stall_cnt=2.
